// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and types for the program counter
//
// Holds the default instruction-memory address width, the default reset PC,
// the sequential step size and the next-PC select encoding used by
// program_counter. No ports.

package pc_pkg;

    // Default width of the instruction-memory word address.
    localparam int          ADDR_W_DEFAULT   = 11;

    // Default PC value loaded while reset is asserted.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Byte distance between consecutive 32-bit instructions.
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Source of the next PC value.
    typedef enum logic [1:0] {
        PC_SEL_HOLD   = 2'd0,
        PC_SEL_INC    = 2'd1,
        PC_SEL_TARGET = 2'd2
    } pc_sel_e;

    // Instructions are word aligned, so a computed target always has its
    // low two byte-address bits cleared before it is loaded.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - 32-bit program counter with hold, increment and branch
//
// Ports:
//   clk           in   1       rising-edge clock for all state
//   rst_n         in   1       asynchronous active-low reset, forces PC to RESET_PC
//   ALU_out       in   32      branch/jump target byte address
//   PC_enable     in   1       1: advance or branch this cycle, 0: hold
//   branch        in   1       with PC_enable, load aligned ALU_out instead of PC+4
//   inst_mem_addr out  ADDR_W  instruction-memory word address, pc[ADDR_W+1:2]
//   pc_out        out  32      current PC byte address (registered)
//   pc_plus4      out  32      pc_out + 4, combinational, wraps modulo 2^32

module program_counter
    import pc_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ALU_out,
    input  logic              PC_enable,
    input  logic              branch,
    output logic [ADDR_W-1:0] inst_mem_addr,
    output logic [31:0]       pc_out,
    output logic [31:0]       pc_plus4
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_inc;
    pc_sel_e     pc_sel;

    // 32-bit add discards the carry, giving the required modulo-2^32 wrap
    // for both the sequential step and the link value.
    assign pc_inc = pc_q + PC_STEP;

    // Next-PC select. PC_enable is tested first so that branch and ALU_out
    // have no influence at all while the counter is holding, even when they
    // are undriven.
    always_comb begin
        pc_sel = PC_SEL_HOLD;
        pc_d   = pc_q;
        if (PC_enable) begin
            if (branch) begin
                pc_sel = PC_SEL_TARGET;
            end else begin
                pc_sel = PC_SEL_INC;
            end
        end
        case (pc_sel)
            PC_SEL_INC:    pc_d = pc_inc;
            PC_SEL_TARGET: pc_d = align_word(ALU_out);
            default:       pc_d = pc_q;
        endcase
    end

    // The only state element in the design. Reset is asynchronous so the
    // PC snaps to RESET_PC without waiting for an edge and any update that
    // was being set up in the current cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // All outputs are direct functions of pc_q, so a new PC is visible on
    // every output in the same cycle it is loaded. Upper PC bits above
    // ADDR_W+1 are simply dropped, which wraps the word address naturally.
    assign pc_out        = pc_q;
    assign pc_plus4      = pc_inc;
    assign inst_mem_addr = pc_q[ADDR_W+1:2];

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed self-checking bench for program_counter

module tb_program_counter;

    localparam int ADDR_W = 11;

    logic              clk;
    logic              rst_n;
    logic [31:0]       ALU_out;
    logic              PC_enable;
    logic              branch;
    logic [ADDR_W-1:0] inst_mem_addr;
    logic [31:0]       pc_out;
    logic [31:0]       pc_plus4;

    int n_vec  = 0;
    int n_miss = 0;

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ALU_out       (ALU_out),
        .PC_enable     (PC_enable),
        .branch        (branch),
        .inst_mem_addr (inst_mem_addr),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                             input logic [31:0] plus4);
        check({tag, ".pc"},    pc_out, pc);
        check({tag, ".addr"},  {{(32-ADDR_W){1'b0}}, inst_mem_addr}, addr);
        check({tag, ".plus4"}, pc_plus4, plus4);
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        ALU_out   = 32'h0;
        PC_enable = 1'b0;
        branch    = 1'b0;

        // Reset state, with active inputs that must be ignored.
        #2;
        PC_enable = 1'b1;
        branch    = 1'b1;
        ALU_out   = 32'h0000_0300;
        check_all("rst", 32'h0, 32'h0, 32'h4);
        step();
        check_all("rst_edge", 32'h0, 32'h0, 32'h4);

        // Release reset with the counter held.
        PC_enable = 1'b0;
        branch    = 1'b0;
        rst_n     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_all($sformatf("hold0_%0d", i), 32'h0, 32'h0, 32'h4);
        end

        // Sequential increment.
        PC_enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_all($sformatf("inc_%0d", i), 32'(4 * i), 32'(i), 32'(4 * i + 4));
        end

        // Branch to an unaligned target; low bits cleared, target repeats.
        branch  = 1'b1;
        ALU_out = 32'h0000_000B;
        step();
        check_all("br_b", 32'h8, 32'h2, 32'hC);
        step();
        check_all("br_b_rep", 32'h8, 32'h2, 32'hC);

        // Preload top of address space, then wrap on increment.
        ALU_out = 32'hFFFF_FFFD;
        step();
        check_all("br_top", 32'hFFFF_FFFC, 32'h7FF, 32'h0);
        branch = 1'b0;
        step();
        check_all("wrap", 32'h0, 32'h0, 32'h4);

        // Word-address wrap: bit 13 and above are outside inst_mem_addr.
        branch  = 1'b1;
        ALU_out = 32'h0000_2004;
        step();
        check_all("addr_wrap", 32'h0000_2004, 32'h1, 32'h0000_2008);

        // Branch to 0x40, then hold with branch requested.
        ALU_out = 32'h0000_0040;
        step();
        check_all("br_40", 32'h40, 32'h10, 32'h44);
        PC_enable = 1'b0;
        ALU_out   = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            step();
            check_all($sformatf("hold_br_%0d", i), 32'h40, 32'h10, 32'h44);
        end
        ALU_out = 32'hxxxx_xxxx;
        branch  = 1'bx;
        step();
        check_all("hold_x", 32'h40, 32'h10, 32'h44);

        // Asynchronous reset between edges while a branch is pending.
        PC_enable = 1'b1;
        branch    = 1'b1;
        ALU_out   = 32'h0000_0200;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 32'h4);
        step();
        check_all("rst_pending", 32'h0, 32'h0, 32'h4);

        // First update on the first edge with reset high.
        branch = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        check_all("post_rst", 32'h4, 32'h1, 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter ADDR_W, default 11: width of the instruction-memory word address.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ALU_out  input  32  branch/jump target byte address, computed by the ALU.
REQ-006 PC_enable  input  1  when high, PC advances or branches this cycle; when low, PC holds.
REQ-007 branch  input  1  when high with PC_enable, PC loads the target instead of incrementing.
REQ-008 inst_mem_addr  output  ADDR_W  word address to instruction memory, equal to pc[ADDR_W+1:2].
REQ-009 pc_out  output  32  current PC byte address, registered.
REQ-010 pc_plus4  output  32  pc_out + 4, combinational, for link-register writeback.

Function
REQ-011 PC SHALL be a 32-bit byte-address register; all outputs derive from it with no extra latency.
REQ-012 PC_enable=0: PC SHALL hold its value, regardless of branch and ALU_out (including X/undriven values).
REQ-013 PC_enable=1, branch=0: PC SHALL become PC+4 on the next rising edge.
REQ-014 PC_enable=1, branch=1: PC SHALL become {ALU_out[31:2],2'b00} on the next rising edge; the low two target bits are forced to zero.
REQ-015 A branch SHALL take effect in one cycle; inst_mem_addr SHALL reflect the new PC in the same cycle PC updates.
REQ-016 Increment SHALL wrap modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000; pc_plus4 SHALL wrap the same way.
REQ-017 inst_mem_addr SHALL wrap naturally, since upper PC bits beyond ADDR_W+1 are ignored.
REQ-018 A held branch=1 with PC_enable=1 and constant ALU_out SHALL reload the same target every cycle.

Reset
REQ-019 rst_n low SHALL immediately, without waiting for a clock edge, force PC=RESET_PC; then inst_mem_addr=RESET_PC[ADDR_W+1:2], pc_out=RESET_PC and pc_plus4=RESET_PC+4.
REQ-020 While rst_n is low, PC SHALL ignore all other inputs.
REQ-021 After rst_n deasserts, the first update SHALL occur on the first rising edge at which rst_n is high.
REQ-022 Reset asserted mid-operation, including during a branch cycle, SHALL discard any pending update.

Structure
REQ-023 Package pc_pkg SHALL hold ADDR_W default, RESET_PC default and the PC_STEP=4 constant.
REQ-024 The next-PC select (hold / +4 / target) SHALL be a single combinational block inside program_counter; no sub-module is required.
REQ-025 The design SHALL contain exactly one 32-bit register and no latches.

Verification
REQ-026 Reset low, then high with PC_enable=0 for 2 cycles -> pc_out=0, inst_mem_addr=0 throughout.
REQ-027 PC_enable=1, branch=0 for 3 edges -> pc_out 4, 8, 12; inst_mem_addr 1, 2, 3.
REQ-028 PC_enable=1, branch=1, ALU_out=32'h0000_000B -> pc_out=32'h8, inst_mem_addr=2, pc_plus4=32'hC; the target repeats on each following edge.
REQ-029 PC preloaded to 32'hFFFF_FFFC via branch, then increment -> pc_out=0, inst_mem_addr=0.
REQ-030 Assert rst_n low between clock edges with PC=32'h40 -> PC=0 immediately, before the next edge.
REQ-031 PC_enable=0, branch=1, ALU_out=32'h100 for 4 edges -> PC unchanged.
